// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S defaults, channel encoding and frame-length helper.
package i2s_pkg;
    localparam int SLOT_BITS_DEF = 32;

    typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} chan_e;

    function automatic int frame_clocks(input int slot_bits, input int bclk_div);
        return 4 * slot_bits * bclk_div;
    endfunction
endpackage

// File: rtl/i2s_clock_gen.sv
// i2s_clock_gen: BCLK divider, period counter, word select and fall/load strobes.
module i2s_clock_gen
    import i2s_pkg::*;
#(
    parameter int SLOT_BITS = SLOT_BITS_DEF,
    parameter int BCLK_DIV  = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic bclk_o,
    output logic lrclk_o,
    output logic fall_o,
    output logic load_o
);
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PW = $clog2(2 * SLOT_BITS);

    logic [DW-1:0] div_q, div_d;
    logic [PW-1:0] per_q, per_d;
    logic          bclk_q, bclk_d;
    logic          wrap;

    always_comb begin
        wrap    = div_q == DW'(BCLK_DIV - 1);
        div_d   = wrap ? '0 : div_q + DW'(1);
        bclk_d  = wrap ? ~bclk_q : bclk_q;
        fall_o  = wrap & bclk_q;
        per_d   = !fall_o ? per_q : (per_q == PW'(2 * SLOT_BITS - 1)) ? '0 : per_q + PW'(1);
        load_o  = fall_o & (per_q == '0);
        bclk_o  = bclk_q;
        // Word select only moves with per_cnt, so it already leads data by one period.
        lrclk_o = (per_q >= PW'(SLOT_BITS)) ? RIGHT : LEFT;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q  <= '0;
            per_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            per_q  <= per_d;
            bclk_q <= bclk_d;
        end
    end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter with a one-pair holding register and underrun replay.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int AUDIO_BITS = 24,
    parameter int SLOT_BITS  = SLOT_BITS_DEF,
    parameter int BCLK_DIV   = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [AUDIO_BITS-1:0] sample_l_i,
    input  logic [AUDIO_BITS-1:0] sample_r_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic                  bclk_o,
    output logic                  lrclk_o,
    output logic                  sdata_o,
    output logic                  frame_tick_o,
    output logic                  underrun_o
);
    localparam int SW  = 2 * SLOT_BITS;
    localparam int PAD = SLOT_BITS - AUDIO_BITS;

    logic [AUDIO_BITS-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [AUDIO_BITS-1:0] last_l_q, last_l_d, last_r_q, last_r_d;
    logic [AUDIO_BITS-1:0] src_l, src_r;
    logic [SW-1:0]         shift_q, shift_d;
    logic                  ready_q, ready_d;
    logic                  fall, load, take;

    i2s_clock_gen #(
        .SLOT_BITS(SLOT_BITS),
        .BCLK_DIV (BCLK_DIV)
    ) u_clk (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .bclk_o (bclk_o),
        .lrclk_o(lrclk_o),
        .fall_o (fall),
        .load_o (load)
    );

    always_comb begin
        take     = valid_i & ready_q;
        src_l    = ready_q ? last_l_q : hold_l_q;
        src_r    = ready_q ? last_r_q : hold_r_q;
        // A transfer in the load cycle fills holding for the next frame, not this one.
        ready_d  = take ? 1'b0 : (load ? 1'b1 : ready_q);
        hold_l_d = take ? sample_l_i : (load ? '0 : hold_l_q);
        hold_r_d = take ? sample_r_i : (load ? '0 : hold_r_q);
        last_l_d = load ? src_l : last_l_q;
        last_r_d = load ? src_r : last_r_q;
        shift_d  = load ? {src_l, {PAD{1'b0}}, src_r, {PAD{1'b0}}}
                 : fall ? {shift_q[SW-2:0], 1'b0} : shift_q;
        ready_o      = ready_q;
        sdata_o      = shift_q[SW-1];
        frame_tick_o = load;
        underrun_o   = load & ready_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_l_q <= '0;
            hold_r_q <= '0;
            last_l_q <= '0;
            last_r_q <= '0;
            shift_q  <= '0;
            ready_q  <= 1'b1;
        end else begin
            hold_l_q <= hold_l_d;
            hold_r_q <= hold_r_d;
            last_l_q <= last_l_d;
            last_r_q <= last_r_d;
            shift_q  <= shift_d;
            ready_q  <= ready_d;
        end
    end
endmodule
